// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes in the stages after D
// (stage 0 = E ... stage NUM_STAGES-1 = W). It drives the D-stage stall and
// the per-operand forward selects, and inserts a bubble into E on stall or flush.
module hazard_scoreboard #(
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int TW         = 2,
  localparam int FWD_W     = $clog2(NUM_STAGES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic              issue_we,
  input  logic [REG_AW-1:0] issue_addr,
  input  logic [TW-1:0]     issue_tnew,
  input  logic              flush,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic              rs_ren,
  input  logic              rt_ren,
  input  logic [TW-1:0]     rs_tuse,
  input  logic [TW-1:0]     rt_tuse,
  output logic              stall,
  output logic [FWD_W-1:0]  fwd_rs,
  output logic [FWD_W-1:0]  fwd_rt,
  output logic              w_we,
  output logic [REG_AW-1:0] w_addr
);

  logic [NUM_STAGES-1:0] valid_q;
  logic [NUM_STAGES-1:0] we_q;
  logic [REG_AW-1:0]     addr_q [NUM_STAGES];
  logic [TW-1:0]         tnew_q [NUM_STAGES];

  logic [NUM_STAGES-1:0] live;
  logic                  rs_found, rt_found;
  logic [TW-1:0]         rs_tnew, rt_tnew;
  logic [FWD_W-1:0]      rs_stage, rt_stage;
  logic                  rs_stall, rt_stall;

  // Entries that can produce a hazard; $0 is never live.
  always_comb begin
    live = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      live[k] = valid_q[k] & we_q[k] & (addr_q[k] != '0);
    end
  end

  // rs port: youngest live match, then stall request and forward select.
  always_comb begin
    rs_found = 1'b0;
    rs_tnew  = '0;
    rs_stage = '0;
    if (rs_ren) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        if (!rs_found && live[k] && (addr_q[k] == rs_addr)) begin
          rs_found = 1'b1;
          rs_tnew  = tnew_q[k];
          rs_stage = FWD_W'(k + 1);
        end
      end
    end
    rs_stall = rs_found && (rs_tnew > rs_tuse);
    fwd_rs   = (rs_found && (rs_tnew == '0)) ? rs_stage : '0;
  end

  // rt port: same search as rs, evaluated independently.
  always_comb begin
    rt_found = 1'b0;
    rt_tnew  = '0;
    rt_stage = '0;
    if (rt_ren) begin
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        if (!rt_found && live[k] && (addr_q[k] == rt_addr)) begin
          rt_found = 1'b1;
          rt_tnew  = tnew_q[k];
          rt_stage = FWD_W'(k + 1);
        end
      end
    end
    rt_stall = rt_found && (rt_tnew > rt_tuse);
    fwd_rt   = (rt_found && (rt_tnew == '0)) ? rt_stage : '0;
  end

  // Stall and last-stage write port are pure functions of current state.
  always_comb begin
    stall  = rs_stall | rt_stall;
    w_we   = we_q[NUM_STAGES-1];
    w_addr = addr_q[NUM_STAGES-1];
  end

  // Entry pipeline: shift with saturating tnew decrement, load or bubble stage 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      we_q    <= '0;
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
        addr_q[k] <= '0;
        tnew_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 1; k < NUM_STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
        we_q[k]    <= we_q[k-1];
        addr_q[k]  <= addr_q[k-1];
        tnew_q[k]  <= (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - 1'b1;
      end
      if (stall || flush) begin
        valid_q[0] <= 1'b0;
        we_q[0]    <= 1'b0;
        addr_q[0]  <= '0;
        tnew_q[0]  <= '0;
      end else begin
        valid_q[0] <= issue_valid;
        we_q[0]    <= issue_we & (issue_addr != '0);
        addr_q[0]  <= issue_addr;
        tnew_q[0]  <= issue_tnew;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios with literal expectations,
// then random traffic, all checked every cycle against a history-based model.
module tb_hazard_scoreboard;
  localparam int NS = 3;
  localparam int AW = 5;
  localparam int TWD = 2;
  localparam int FW = 2;

  logic clk = 1'b0;
  logic reset, issue_valid, issue_we, flush, rs_ren, rt_ren;
  logic [AW-1:0] issue_addr, rs_addr, rt_addr;
  logic [TWD-1:0] issue_tnew, rs_tuse, rt_tuse;
  logic stall, w_we;
  logic [FW-1:0] fwd_rs, fwd_rt;
  logic [AW-1:0] w_addr;

  int checks = 0;
  int errors = 0;
  bit model_ok = 0;

  hazard_scoreboard #(.NUM_STAGES(NS), .REG_AW(AW), .TW(TWD)) dut (
    .clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_we(issue_we),
    .issue_addr(issue_addr), .issue_tnew(issue_tnew), .flush(flush),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_ren(rs_ren), .rt_ren(rt_ren),
    .rs_tuse(rs_tuse), .rt_tuse(rt_tuse), .stall(stall), .fwd_rs(fwd_rs),
    .fwd_rt(fwd_rt), .w_we(w_we), .w_addr(w_addr)
  );

  always #5 clk = ~clk;

  // History of what entered E on each of the last NS edges (index 0 = newest).
  // An instruction sitting k stages past E has had its tnew reduced k times.
  typedef struct {
    bit v;
    bit we;
    int addr;
    int tnew;
  } ent_t;
  ent_t hist[$];

  function automatic int eff_tnew(int k);
    return (hist[k].tnew > k) ? hist[k].tnew - k : 0;
  endfunction

  // Returns index of youngest live matching entry, or -1.
  function automatic int find_match(bit ren, int addr);
    if (!ren) return -1;
    for (int k = 0; k < NS; k++)
      if (hist[k].v && hist[k].we && hist[k].addr != 0 && hist[k].addr == addr) return k;
    return -1;
  endfunction

  function automatic bit exp_stall();
    int a, b;
    a = find_match(rs_ren, int'(rs_addr));
    b = find_match(rt_ren, int'(rt_addr));
    return (a >= 0 && eff_tnew(a) > int'(rs_tuse)) || (b >= 0 && eff_tnew(b) > int'(rt_tuse));
  endfunction

  function automatic int exp_fwd(bit ren, int addr);
    int m;
    m = find_match(ren, addr);
    if (m >= 0 && eff_tnew(m) == 0) return m + 1;
    return 0;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Model update on every edge.
  always @(posedge clk) begin
    ent_t e, dropped;
    if (!reset) begin
      hist.delete();
      for (int k = 0; k < NS; k++) hist.push_back('{0, 0, 0, 0});
      model_ok = 1;
    end else if (model_ok) begin
      if (exp_stall() || flush) e = '{0, 0, 0, 0};
      else e = '{issue_valid, issue_we && issue_addr != 0, int'(issue_addr), int'(issue_tnew)};
      hist.push_front(e);
      dropped = hist.pop_back();
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (model_ok) begin
      check("m_stall", int'(stall), int'(exp_stall()));
      check("m_fwd_rs", int'(fwd_rs), exp_fwd(rs_ren, int'(rs_addr)));
      check("m_fwd_rt", int'(fwd_rt), exp_fwd(rt_ren, int'(rt_addr)));
      check("m_w_we", int'(w_we), int'(hist[NS-1].we));
      check("m_w_addr", int'(w_addr), hist[NS-1].addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic iss(bit v, bit we, int a, int t);
    issue_valid = v; issue_we = we; issue_addr = AW'(a); issue_tnew = TWD'(t);
  endtask

  task automatic rd(bit rsr, int rsa, int rsu, bit rtr, int rta, int rtu);
    rs_ren = rsr; rs_addr = AW'(rsa); rs_tuse = TWD'(rsu);
    rt_ren = rtr; rt_addr = AW'(rta); rt_tuse = TWD'(rtu);
  endtask

  task automatic idle(int n);
    iss(0, 0, 0, 0); rd(0, 0, 0, 0, 0, 0); flush = 0;
    repeat (n) tick();
  endtask

  initial begin
    reset = 0; flush = 0;
    iss(0, 0, 0, 0); rd(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    neg();
    check("rst_stall", int'(stall), 0);
    check("rst_fwd_rs", int'(fwd_rs), 0);
    check("rst_w_we", int'(w_we), 0);
    check("rst_w_addr", int'(w_addr), 0);
    reset = 1;
    idle(2);

    // Load-use: lw $8 tnew=2, then add reading rs=8 tuse=1.
    iss(1, 1, 8, 2); tick();
    iss(1, 1, 10, 1); rd(1, 8, 1, 0, 0, 0);
    neg(); check("lu_c1_stall", int'(stall), 1); check("lu_c1_fwd", int'(fwd_rs), 0);
    tick();
    neg(); check("lu_c2_stall", int'(stall), 0); check("lu_c2_fwd", int'(fwd_rs), 0);
    tick();
    idle(4);

    // Branch after lw: rs=8 tuse=0.
    iss(1, 1, 8, 2); tick();
    iss(1, 0, 0, 0); rd(1, 8, 0, 0, 0, 0);
    neg(); check("br_c1_stall", int'(stall), 1);
    tick();
    neg(); check("br_c2_stall", int'(stall), 1);
    tick();
    neg(); check("br_c3_stall", int'(stall), 0); check("br_c3_fwd", int'(fwd_rs), 3);
    tick();
    idle(4);

    // Youngest match priority.
    iss(1, 1, 9, 1); tick();
    iss(1, 1, 9, 1); tick();
    iss(0, 0, 0, 0); rd(0, 0, 0, 1, 9, 1);
    neg(); check("yp_stall", int'(stall), 0); check("yp_fwd_rt0", int'(fwd_rt), 0);
    tick();
    neg(); check("yp_fwd_rt1", int'(fwd_rt), 2);
    idle(4);

    // $0 write and ren gating.
    iss(1, 1, 8, 0); tick();
    iss(1, 1, 0, 2); tick();
    iss(0, 0, 0, 0); rd(1, 0, 0, 0, 8, 0);
    neg(); check("z_stall", int'(stall), 0); check("z_fwd_rs", int'(fwd_rs), 0);
    check("z_fwd_rt", int'(fwd_rt), 0);
    tick();
    neg(); check("z_w8_we", int'(w_we), 1); check("z_w8_addr", int'(w_addr), 8);
    tick();
    neg(); check("z_w0_we", int'(w_we), 0);
    idle(4);

    // Flush together with stall: one bubble, older entries shift.
    iss(1, 1, 8, 2); tick();
    iss(1, 1, 11, 1); rd(1, 8, 1, 0, 0, 0); flush = 1;
    neg(); check("fs_stall", int'(stall), 1);
    tick();
    flush = 0; iss(0, 0, 0, 0);
    neg(); check("fs_m_stall", int'(stall), 0);
    tick();
    neg(); check("fs_w_we", int'(w_we), 1); check("fs_w_addr", int'(w_addr), 8);
    tick();
    neg(); check("fs_bub_we", int'(w_we), 0);
    idle(4);

    // Reset mid-operation with three live entries.
    iss(1, 1, 5, 2); tick();
    iss(1, 1, 6, 2); tick();
    iss(1, 1, 7, 2); tick();
    iss(1, 1, 12, 1); rd(1, 7, 0, 1, 5, 0);
    neg(); check("rm_pre_stall", int'(stall), 1); check("rm_pre_fwd_rt", int'(fwd_rt), 3);
    reset = 0; tick();
    reset = 1; iss(0, 0, 0, 0); rd(1, 7, 0, 1, 12, 0);
    neg(); check("rm_stall", int'(stall), 0); check("rm_fwd_rs", int'(fwd_rs), 0);
    check("rm_fwd_rt", int'(fwd_rt), 0); check("rm_w_we", int'(w_we), 0);
    tick(); tick();
    neg(); check("rm_no_capture", int'(w_we), 0);
    idle(2);

    // Random traffic over a small register set to provoke matches.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
      flush = ($urandom_range(0, 9) == 0);
      iss($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 3), $urandom_range(0, 3));
      rd($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
         $urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3));
      tick();
    end
    reset = 1;
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
